// File: rtl/fifo_rr_sched.sv
// Round-robin read scheduler draining NQ fifoctrl queues into one valid/ready stream.
// Define FIFO_SCHED_Q0_PRIO_EN to give queue 0 strict priority and unlimited bursts.
module fifo_rr_sched #(
  parameter int NQ    = 4,
  parameter int QW    = 2,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NQ-1:0]    q_notempty,
  output logic [NQ-1:0]    q_rd,
  input  logic [NQ*DW-1:0] q_rdata,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DW-1:0]    out_data,
  output logic [QW-1:0]    out_qid,
  output logic             busy
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t        state_reg, state_next;
  logic [QW-1:0] grant_reg, grant_next;
  logic [QW-1:0] last_reg, last_next;
  logic [7:0]    burst_cnt_reg, burst_cnt_next;
  logic          inflight_reg;
  logic [QW-1:0] inflight_qid_reg;
  logic [1:0]    skid_cnt_reg;
  logic [DW-1:0] skid0_data_reg, skid1_data_reg;
  logic [QW-1:0] skid0_qid_reg, skid1_qid_reg;

  logic [DW-1:0] q_word [NQ];
  logic          issue, pop, push, space, burst_limit;
  logic [2:0]    occupancy;
  logic [QW-1:0] pick, cand;
  logic          pick_vld;

  genvar gi;
  generate
    for (gi = 0; gi < NQ; gi++) begin : g_queue
      assign q_word[gi] = q_rdata[gi*DW +: DW];
      assign q_rd[gi]   = issue && (grant_reg == QW'(gi));
    end
  endgenerate

  assign out_vld  = (skid_cnt_reg != 2'd0);
  assign out_data = skid0_data_reg;
  assign out_qid  = skid0_qid_reg;
  assign pop      = out_vld && out_rdy;
  assign push     = inflight_reg;
  assign busy     = (state_reg != ST_IDLE) || inflight_reg || (skid_cnt_reg != 2'd0);

  // Count words already committed to the skid; a new read is allowed only if it still fits.
  assign occupancy = {1'b0, skid_cnt_reg} - {2'b00, pop} + {2'b00, inflight_reg};
  assign space     = (occupancy <= 3'd1);

  // Scan in reverse so the candidate nearest to last+1 is the one left standing.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
`ifdef FIFO_SCHED_Q0_PRIO_EN
    for (int i = NQ - 1; i >= 1; i--) begin
      cand = QW'(1 + ((int'(last_reg) - 1 + i) % (NQ - 1)));
      if (q_notempty[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
    if (q_notempty[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
    burst_limit = (grant_reg != '0);
`else
    for (int i = NQ; i >= 1; i--) begin
      cand = QW'((int'(last_reg) + i) % NQ);
      if (q_notempty[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
    burst_limit = 1'b1;
`endif
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    last_next      = last_reg;
    burst_cnt_next = burst_cnt_reg;
    issue          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_next     = pick;
          burst_cnt_next = 8'd0;
          state_next     = ST_BURST;
        end
      end
      ST_BURST: begin
        issue = q_notempty[grant_reg] && space;
        if (issue) burst_cnt_next = burst_cnt_reg + 8'd1;
        if ((issue && burst_limit && (burst_cnt_reg == 8'(BURST - 1))) || !q_notempty[grant_reg]) begin
          state_next = ST_IDLE;
`ifdef FIFO_SCHED_Q0_PRIO_EN
          // Queue 0 stays outside the rotation so 1..NQ-1 keep their own order.
          if (grant_reg != '0) last_next = grant_reg;
`else
          last_next = grant_reg;
`endif
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      grant_reg        <= '0;
      last_reg         <= QW'(NQ - 1);
      burst_cnt_reg    <= 8'd0;
      inflight_reg     <= 1'b0;
      inflight_qid_reg <= '0;
    end else begin
      state_reg        <= state_next;
      grant_reg        <= grant_next;
      last_reg         <= last_next;
      burst_cnt_reg    <= burst_cnt_next;
      inflight_reg     <= issue;
      inflight_qid_reg <= grant_reg;
    end
  end

  // Two-entry skid; entry 0 is always the head presented on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_cnt_reg   <= 2'd0;
      skid0_data_reg <= '0;
      skid0_qid_reg  <= '0;
      skid1_data_reg <= '0;
      skid1_qid_reg  <= '0;
    end else if (push && pop) begin
      if (skid_cnt_reg == 2'd2) begin
        skid0_data_reg <= skid1_data_reg;
        skid0_qid_reg  <= skid1_qid_reg;
        skid1_data_reg <= q_word[inflight_qid_reg];
        skid1_qid_reg  <= inflight_qid_reg;
      end else begin
        skid0_data_reg <= q_word[inflight_qid_reg];
        skid0_qid_reg  <= inflight_qid_reg;
      end
    end else if (pop) begin
      skid0_data_reg <= skid1_data_reg;
      skid0_qid_reg  <= skid1_qid_reg;
      skid_cnt_reg   <= skid_cnt_reg - 2'd1;
    end else if (push) begin
      if (skid_cnt_reg == 2'd0) begin
        skid0_data_reg <= q_word[inflight_qid_reg];
        skid0_qid_reg  <= inflight_qid_reg;
      end else begin
        skid1_data_reg <= q_word[inflight_qid_reg];
        skid1_qid_reg  <= inflight_qid_reg;
      end
      skid_cnt_reg <= skid_cnt_reg + 2'd1;
    end
  end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench for fifo_rr_sched: models NQ fifoctrl queues with 1-cycle read memories.
module tb_fifo_rr_sched;
  localparam int NQ = 4, QW = 2, DW = 8, BURST = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NQ-1:0]    q_notempty, q_rd;
  logic [NQ*DW-1:0] q_rdata;
  logic             out_vld, out_rdy, busy;
  logic [DW-1:0]    out_data;
  logic [QW-1:0]    out_qid;

  always #5 clk = ~clk;

  fifo_rr_sched #(.NQ(NQ), .QW(QW), .DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .q_notempty(q_notempty), .q_rd(q_rd), .q_rdata(q_rdata),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_qid(out_qid), .busy(busy)
  );

  // Queue model: wr_ptr owned by the stimulus, rd_ptr advanced by q_rd.
  logic [DW-1:0] mem [NQ][256];
  int            wr_ptr [NQ] = '{default: 0};
  int            rd_ptr [NQ] = '{default: 0};
  logic [DW-1:0] rdata_reg [NQ] = '{default: '0};

  always_comb begin
    q_notempty = '0;
    q_rdata    = '0;
    for (int i = 0; i < NQ; i++) begin
      q_notempty[i]        = (wr_ptr[i] != rd_ptr[i]);
      q_rdata[i*DW +: DW]  = rdata_reg[i];
    end
  end

  always @(posedge clk)
    for (int i = 0; i < NQ; i++)
      if (q_rd[i]) begin
        rdata_reg[i] <= mem[i][rd_ptr[i] % 256];
        rd_ptr[i]    <= rd_ptr[i] + 1;
      end

  int n_chk = 0, n_fail = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  function automatic logic [DW-1:0] word(int q, int idx);
    return DW'(q * 64 + (idx + 1) % 64);
  endfunction

  // Monitor: protocol checks plus a log of every accepted word.
  int            n_rd = 0;
  logic [QW-1:0] log_qid [$];
  logic [DW-1:0] log_data [$];
  logic          hold_vld = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [QW-1:0] hold_qid = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
    end else begin
      if (q_rd != '0) begin
        n_rd <= n_rd + 1;
        chk("rd_onehot", 32'($onehot(q_rd)), 32'd1);
        chk("rd_to_empty", 32'(q_rd & ~q_notempty), 32'd0);
      end
      if (hold_vld) begin
        chk("hold_vld", 32'(out_vld), 32'd1);
        chk("hold_word", 32'({out_qid, out_data}), 32'({hold_qid, hold_data}));
      end
      hold_vld  <= out_vld && !out_rdy;
      hold_data <= out_data;
      hold_qid  <= out_qid;
      if (out_vld && out_rdy) begin
        log_qid.push_back(out_qid);
        log_data.push_back(out_data);
        $display("out word: qid=%0d data=0x%02h", out_qid, out_data);
      end
    end
  end

  typedef struct {
    logic          rst_n;
    logic [NQ-1:0] q_rd;
    logic          vld;
    logic [QW-1:0] qid;
    logic [DW-1:0] data;
    logic          busy;
  } row_t;

  typedef struct {
    logic [QW-1:0] qid;
    logic [DW-1:0] data;
  } vec_t;

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(int q, int n);
    for (int k = 0; k < n; k++) begin
      mem[q][wr_ptr[q] % 256] = word(q, wr_ptr[q]);
      wr_ptr[q] = wr_ptr[q] + 1;
    end
  endtask

  task automatic drain(string name);
    bit done = 1'b0;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      done = !busy && (q_notempty == '0);
    end
    chk({name, "_drain"}, 32'(done), 32'd1);
    tick(1);
  endtask

  task automatic check_log(string name, int base, vec_t exp_q[$]);
    chk({name, "_len"}, 32'(log_qid.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < log_qid.size(); i++)
      chk($sformatf("%s[%0d]", name, i), 32'({log_qid[base+i], log_data[base+i]}),
          32'({exp_q[i].qid, exp_q[i].data}));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows [16];
    vec_t exp_q [$];
    int   base, r0, b[NQ];

    rst_n   = 1'b0;
    out_rdy = 1'b1;
    for (int q = 0; q < NQ; q++) load(q, 1);

    // Reset with every queue holding one word, then release: grants go 0,1,2,3.
    rows[0]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    rows[1]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    rows[2]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    rows[3]  = '{1'b1, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b1};
    rows[4]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b1};
    rows[5]  = '{1'b1, 4'b0000, 1'b1, 2'd0, word(0, 0), 1'b1};
    rows[6]  = '{1'b1, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b1};
    rows[7]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b1};
    rows[8]  = '{1'b1, 4'b0000, 1'b1, 2'd1, word(1, 0), 1'b1};
    rows[9]  = '{1'b1, 4'b0100, 1'b0, 2'd0, 8'h00, 1'b1};
    rows[10] = '{1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b1};
    rows[11] = '{1'b1, 4'b0000, 1'b1, 2'd2, word(2, 0), 1'b1};
    rows[12] = '{1'b1, 4'b1000, 1'b0, 2'd0, 8'h00, 1'b1};
    rows[13] = '{1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b1};
    rows[14] = '{1'b1, 4'b0000, 1'b1, 2'd3, word(3, 0), 1'b1};
    rows[15] = '{1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};

    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      rst_n = rows[k].rst_n;
      @(negedge clk);
      chk($sformatf("row%0d_q_rd", k), 32'(q_rd), 32'(rows[k].q_rd));
      chk($sformatf("row%0d_vld", k), 32'(out_vld), 32'(rows[k].vld));
      chk($sformatf("row%0d_busy", k), 32'(busy), 32'(rows[k].busy));
      if (rows[k].vld)
        chk($sformatf("row%0d_word", k), 32'({out_qid, out_data}), 32'({rows[k].qid, rows[k].data}));
    end
    drain("reset");

    // Single queue: three words, first valid three clocks after IDLE sees notempty.
    b[1] = wr_ptr[1];
    load(1, 3);
    repeat (3) @(negedge clk);
    chk("single_lat_vld_early", 32'(out_vld), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("single_vld%0d", k), 32'(out_vld), 32'd1);
      chk($sformatf("single_word%0d", k), 32'({out_qid, out_data}), 32'({2'd1, word(1, b[1] + k)}));
    end
    @(negedge clk);
    chk("single_end_vld", 32'(out_vld), 32'd0);
    chk("single_end_busy", 32'(busy), 32'd0);
    drain("single");

`ifndef FIFO_SCHED_Q0_PRIO_EN
    // Round-robin: 10 words per queue, bursts of 4, 4, then the 2 left over.
    pulse_reset();
    base = log_qid.size();
    for (int q = 0; q < NQ; q++) begin
      b[q] = wr_ptr[q];
      load(q, 10);
    end
    drain("rr");
    exp_q.delete();
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < NQ; q++)
        for (int j = 0; j < ((r < 2) ? 4 : 2); j++)
          exp_q.push_back('{QW'(q), word(q, b[q] + r * 4 + j)});
    check_log("rr", base, exp_q);
`endif

    // Backpressure: with out_rdy low only two reads may be outstanding.
    out_rdy = 1'b0;
    r0 = n_rd;
    base = log_qid.size();
    b[2] = wr_ptr[2];
    load(2, 4);
    tick(20);
    chk("bp_reads", 32'(n_rd - r0), 32'd2);
    @(negedge clk);
    chk("bp_vld", 32'(out_vld), 32'd1);
    chk("bp_word", 32'({out_qid, out_data}), 32'({2'd2, word(2, b[2])}));
    tick(1);
    out_rdy = 1'b1;
    drain("bp");
    exp_q.delete();
    for (int j = 0; j < 4; j++) exp_q.push_back('{2'd2, word(2, b[2] + j)});
    check_log("bp", base, exp_q);

`ifndef FIFO_SCHED_Q0_PRIO_EN
    // Mid-burst empty: q2 gets only two reads, then the grant moves to q3, not q0.
    load(1, 1);
    drain("mid_a");
    base = log_qid.size();
    for (int q = 0; q < NQ; q++) b[q] = wr_ptr[q];
    load(0, 2);
    load(2, 2);
    load(3, 2);
    drain("mid_b");
    exp_q.delete();
    exp_q.push_back('{2'd2, word(2, b[2])});
    exp_q.push_back('{2'd2, word(2, b[2] + 1)});
    exp_q.push_back('{2'd3, word(3, b[3])});
    exp_q.push_back('{2'd3, word(3, b[3] + 1)});
    exp_q.push_back('{2'd0, word(0, b[0])});
    exp_q.push_back('{2'd0, word(0, b[0] + 1)});
    check_log("mid", base, exp_q);
`else
    // Queue-0 priority: q0 drains fully, and a refill preempts at the next IDLE.
    begin
      bit seen = 1'b0;
      pulse_reset();
      base = log_qid.size();
      b[0] = wr_ptr[0];
      b[1] = wr_ptr[1];
      load(0, 6);
      load(1, 6);
      for (int k = 0; k < 200 && !seen; k++) begin
        @(negedge clk);
        seen = out_vld && (out_qid == 2'd1);
      end
      chk("prio_q1_start", 32'(seen), 32'd1);
      tick(1);
      load(0, 2);
      drain("prio");
      exp_q.delete();
      for (int j = 0; j < 6; j++) exp_q.push_back('{2'd0, word(0, b[0] + j)});
      for (int j = 0; j < 4; j++) exp_q.push_back('{2'd1, word(1, b[1] + j)});
      for (int j = 6; j < 8; j++) exp_q.push_back('{2'd0, word(0, b[0] + j)});
      for (int j = 4; j < 6; j++) exp_q.push_back('{2'd1, word(1, b[1] + j)});
      check_log("prio", base, exp_q);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
